// File: rtl/mpmc11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_pkg
// Brief    : Shared types and helpers for the MPMC11 DDR back end.
// Revision : 1.0
// ============================================================================
package mpmc11_pkg;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_RUN   = 2'd1,
        SS_DRAIN = 2'd2,
        SS_DONE  = 2'd3
    } strip_fsm_t;

    // Width needed to count from 0 up to the larger of the two gap limits.
    function automatic int gap_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpmc11_strip_idx.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_strip_idx
// Brief    : Strip index with last-strip compare and sticky all-done flag.
// Revision : 1.0
// ============================================================================
module mpmc11_strip_idx #(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_clr,
    input  logic          i_adv,
    input  logic [SW-1:0] i_last,
    output logic [SW-1:0] o_idx,
    output logic          o_all,
    output logic          o_at_last
);

    logic [SW-1:0] r_idx;
    logic          r_all;

    assign o_idx     = r_idx;
    assign o_all     = r_all;
    assign o_at_last = (r_idx == i_last);

    // The index holds on the last strip; the flag marks completion so a
    // full 2^SW-strip burst never wraps back to zero.
    always_ff @(posedge clk) begin
        if (!rstn || i_clr) begin
            r_idx <= '0;
            r_all <= 1'b0;
        end else if (i_adv && !r_all) begin
            if (o_at_last) begin
                r_all <= 1'b1;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mpmc11_strip_seq.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_strip_seq
// Brief    : Read/write strip sequencer between port arbiter and MIG app/wdf.
// Revision : 1.0
// ============================================================================
module mpmc11_strip_seq
    import mpmc11_pkg::*;
#(
    parameter int SW        = 8,
    parameter int MAX_OUTST = 4,
    parameter int WR_LEAD   = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_is_write,
    input  logic [SW-1:0] i_num_strips,
    input  logic          i_app_rdy,
    input  logic          i_wdf_rdy,
    input  logic          i_rd_valid,
    output logic          o_cmd_en,
    output logic          o_wdf_wren,
    output logic          o_wdf_end,
    output logic [SW-1:0] o_cmd_idx,
    output logic [SW-1:0] o_data_idx,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int                 c_GAP_W     = gap_width(MAX_OUTST, WR_LEAD);
    localparam logic [c_GAP_W-1:0] c_MAX_OUTST = c_GAP_W'(MAX_OUTST);
    localparam logic [c_GAP_W-1:0] c_WR_LEAD   = c_GAP_W'(WR_LEAD);

    strip_fsm_t         r_state;
    logic               r_write;
    logic [SW-1:0]      r_last;
    logic [c_GAP_W-1:0] r_gap;
    logic               r_err;

    logic          w_run;
    logic          w_live;
    logic          w_cmd_en;
    logic          w_wdf_wren;
    logic          w_cmd_xfer;
    logic          w_wdf_xfer;
    logic          w_rd_ok;
    logic          w_rd_xfer;
    logic          w_rd_err;
    logic          w_data_xfer;
    logic          w_start_acc;
    logic          w_abort_acc;
    logic          w_clr;
    logic          w_gap_inc;
    logic          w_gap_dec;
    logic [SW-1:0] w_cmd_idx;
    logic [SW-1:0] w_data_idx;
    logic          w_cmd_all;
    logic          w_data_all;
    logic          w_cmd_at_last;
    logic          w_data_at_last;
    logic          w_cmd_all_nxt;
    logic          w_data_all_nxt;

    assign w_run  = (r_state == SS_RUN);
    assign w_live = (r_state == SS_RUN) || (r_state == SS_DRAIN);

    // Reads are throttled by outstanding commands; a write command may only
    // follow a beat already accepted by the write-data FIFO.
    assign w_cmd_en   = w_run && !w_cmd_all &&
                        (r_write ? (r_gap != '0) : (r_gap < c_MAX_OUTST));
    assign w_wdf_wren = r_write && w_live && !w_data_all && (r_gap < c_WR_LEAD);

    assign w_cmd_xfer  = w_cmd_en && i_app_rdy;
    assign w_wdf_xfer  = w_wdf_wren && i_wdf_rdy;
    assign w_rd_ok     = w_live && !r_write && (r_gap != '0);
    assign w_rd_xfer   = i_rd_valid && w_rd_ok;
    assign w_rd_err    = i_rd_valid && w_live && !w_rd_ok;
    assign w_data_xfer = r_write ? w_wdf_xfer : w_rd_xfer;

    assign w_start_acc = (r_state == SS_IDLE) && i_start && !i_abort;
    assign w_abort_acc = (r_state != SS_IDLE) && i_abort;
    assign w_clr       = w_start_acc || w_abort_acc;

    assign w_gap_inc = r_write ? w_wdf_xfer : w_cmd_xfer;
    assign w_gap_dec = r_write ? w_cmd_xfer : w_rd_xfer;

    // Completion is judged on the flags as they will be after this edge, so
    // a burst whose last command and last beat coincide ends straight from RUN.
    assign w_cmd_all_nxt  = w_cmd_all  || (w_cmd_xfer  && w_cmd_at_last);
    assign w_data_all_nxt = w_data_all || (w_data_xfer && w_data_at_last);

    mpmc11_strip_idx #(.SW(SW)) u_cmd_idx (
        .clk       (clk),
        .rstn      (rstn),
        .i_clr     (w_clr),
        .i_adv     (w_cmd_xfer),
        .i_last    (r_last),
        .o_idx     (w_cmd_idx),
        .o_all     (w_cmd_all),
        .o_at_last (w_cmd_at_last)
    );

    mpmc11_strip_idx #(.SW(SW)) u_data_idx (
        .clk       (clk),
        .rstn      (rstn),
        .i_clr     (w_clr),
        .i_adv     (w_data_xfer),
        .i_last    (r_last),
        .o_idx     (w_data_idx),
        .o_all     (w_data_all),
        .o_at_last (w_data_at_last)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= SS_IDLE;
            r_write <= 1'b0;
            r_last  <= '0;
            r_gap   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_rd_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                SS_IDLE: begin
                    if (w_start_acc) begin
                        r_state <= SS_RUN;
                        r_write <= i_is_write;
                        r_last  <= i_num_strips;
                        r_gap   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                SS_RUN, SS_DRAIN: begin
                    if (w_abort_acc) begin
                        r_state <= SS_IDLE;
                        r_write <= 1'b0;
                        r_last  <= '0;
                        r_gap   <= '0;
                    end else begin
                        if (w_gap_inc && !w_gap_dec) begin
                            r_gap <= r_gap + 1'b1;
                        end else if (w_gap_dec && !w_gap_inc) begin
                            r_gap <= r_gap - 1'b1;
                        end
                        if (w_cmd_all_nxt && w_data_all_nxt) begin
                            r_state <= SS_DONE;
                        end else if (w_cmd_all_nxt) begin
                            r_state <= SS_DRAIN;
                        end
                    end
                end
                SS_DONE: begin
                    r_state <= SS_IDLE;
                    if (w_abort_acc) begin
                        r_write <= 1'b0;
                        r_last  <= '0;
                        r_gap   <= '0;
                    end
                end
                default: begin
                    r_state <= SS_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_en   = w_cmd_en;
    assign o_wdf_wren = w_wdf_wren;
    assign o_wdf_end  = w_wdf_wren;
    assign o_cmd_idx  = w_cmd_idx;
    assign o_data_idx = w_data_idx;
    assign o_busy     = (r_state != SS_IDLE);
    assign o_done     = (r_state == SS_DONE);
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mpmc11_strip_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpmc11_strip_seq
// Brief    : Self-checking bench for the strip sequencer (two parameter sets).
// Revision : 1.0
// ============================================================================
module tb_mpmc11_strip_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       is_write = 1'b0;
    logic [7:0] num_strips = 8'd0;
    logic       app_rdy = 1'b0;
    logic       wdf_rdy = 1'b0;
    logic       rd_valid = 1'b0;

    logic       a_cmd_en, a_wdf_wren, a_wdf_end, a_busy, a_done, a_err;
    logic [7:0] a_cmd_idx, a_data_idx;
    logic       b_cmd_en, b_wdf_wren, b_wdf_end, b_busy, b_done, b_err;
    logic [7:0] b_cmd_idx, b_data_idx;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mpmc11_strip_seq #(.SW(8), .MAX_OUTST(4), .WR_LEAD(2)) u_a (
        .clk(clk), .rstn(rstn), .i_start(start), .i_abort(abort),
        .i_is_write(is_write), .i_num_strips(num_strips), .i_app_rdy(app_rdy),
        .i_wdf_rdy(wdf_rdy), .i_rd_valid(rd_valid), .o_cmd_en(a_cmd_en),
        .o_wdf_wren(a_wdf_wren), .o_wdf_end(a_wdf_end), .o_cmd_idx(a_cmd_idx),
        .o_data_idx(a_data_idx), .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
    );

    mpmc11_strip_seq #(.SW(8), .MAX_OUTST(2), .WR_LEAD(2)) u_b (
        .clk(clk), .rstn(rstn), .i_start(start), .i_abort(abort),
        .i_is_write(is_write), .i_num_strips(num_strips), .i_app_rdy(app_rdy),
        .i_wdf_rdy(wdf_rdy), .i_rd_valid(rd_valid), .o_cmd_en(b_cmd_en),
        .o_wdf_wren(b_wdf_wren), .o_wdf_end(b_wdf_end), .o_cmd_idx(b_cmd_idx),
        .o_data_idx(b_data_idx), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
    );

    // Reference model for u_a: burst described by strip count and the number
    // of commands / data beats completed so far.
    int m_phase;  // 0 idle, 1 active, 2 done
    int m_wr, m_n, m_nc, m_nd;
    bit m_err;

    function automatic bit m_cmd_en();
        return (m_phase == 1) && (m_nc < m_n) &&
               ((m_wr != 0) ? (m_nd > m_nc) : ((m_nc - m_nd) < 4));
    endfunction

    function automatic bit m_wren();
        return (m_wr != 0) && (m_phase == 1) && (m_nd < m_n) && ((m_nd - m_nc) < 2);
    endfunction

    function automatic int m_idx(input int c);
        return (c < m_n) ? c : m_n - 1;
    endfunction

    task automatic model_step();
        bit ce, we, rx;
        if (!rstn) begin
            m_phase = 0; m_wr = 0; m_n = 1; m_nc = 0; m_nd = 0; m_err = 1'b0;
            return;
        end
        case (m_phase)
            0: if (start && !abort) begin
                m_phase = 1; m_wr = int'(is_write); m_n = int'(num_strips) + 1;
                m_nc = 0; m_nd = 0; m_err = 1'b0;
            end
            2: begin
                m_phase = 0;
                if (abort) begin m_nc = 0; m_nd = 0; m_n = 1; end
            end
            default: begin
                ce = m_cmd_en() && app_rdy;
                we = m_wren() && wdf_rdy;
                rx = 1'b0;
                if (rd_valid) begin
                    if (m_wr == 0 && m_nc > m_nd) rx = 1'b1;
                    else m_err = 1'b1;
                end
                if (abort) begin
                    m_phase = 0; m_nc = 0; m_nd = 0; m_n = 1;
                end else begin
                    m_nc += int'(ce);
                    m_nd += (m_wr != 0) ? int'(we) : int'(rx);
                    if (m_nc == m_n && m_nd == m_n) m_phase = 2;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; is_write = 1'b0;
        num_strips = 8'd0; app_rdy = 1'b0; wdf_rdy = 1'b0; rd_valid = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", a_busy); else n_pass++;
        n_checks++; if (a_cmd_en !== 1'b0 || a_wdf_wren !== 1'b0) $display("FAIL reset_en: got cmd_en=%0b wren=%0b want 0/0", a_cmd_en, a_wdf_wren); else n_pass++;
        n_checks++; if (a_done !== 1'b0 || a_err !== 1'b0) $display("FAIL reset_flags: got done=%0b err=%0b want 0/0", a_done, a_err); else n_pass++;
        n_checks++; if (a_cmd_idx !== 8'd0 || a_data_idx !== 8'd0) $display("FAIL reset_idx: got %0d/%0d want 0/0", a_cmd_idx, a_data_idx); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start = 1'b1; is_write = 1'b0; num_strips = 8'd3;
        tick();
        start = 1'b0; rd_valid = 1'b1;   // nothing outstanding yet
        tick();
        rd_valid = 1'b0;
        n_checks++; if (a_err !== 1'b1 || a_busy !== 1'b1) $display("FAIL midrun_pre: got err=%0b busy=%0b want 1/1", a_err, a_busy); else n_pass++;
        app_rdy = 1'b1;
        tick();
        n_checks++; if (a_cmd_idx !== 8'd1) $display("FAIL midrun_idx: got %0d want 1", a_cmd_idx); else n_pass++;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_checks++; if (a_busy !== 1'b0 || a_cmd_en !== 1'b0) $display("FAIL midrun_rst: got busy=%0b cmd_en=%0b want 0/0", a_busy, a_cmd_en); else n_pass++;
        n_checks++; if (a_cmd_idx !== 8'd0 || a_data_idx !== 8'd0 || a_err !== 1'b0) $display("FAIL midrun_clr: got idx=%0d/%0d err=%0b want 0/0/0", a_cmd_idx, a_data_idx, a_err); else n_pass++;
        app_rdy = 1'b0;
    endtask

    task automatic test_read_burst();
        int ncmd = 0;
        int ndone = 0;
        do_reset();
        start = 1'b1; is_write = 1'b0; num_strips = 8'd3; app_rdy = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                n_checks++; if (a_cmd_en !== 1'b1 || a_cmd_idx !== 8'(k)) $display("FAIL rd_cmd%0d: got en=%0b idx=%0d want 1/%0d", k, a_cmd_en, a_cmd_idx, k); else n_pass++;
            end
            if (k == 4) begin
                n_checks++; if (a_data_idx !== 8'd1 || a_busy !== 1'b1) $display("FAIL rd_drain: got data_idx=%0d busy=%0b want 1/1", a_data_idx, a_busy); else n_pass++;
            end
            if (k == 7) begin
                n_checks++; if (a_done !== 1'b1) $display("FAIL rd_done_at7: got %0b want 1", a_done); else n_pass++;
            end
            ncmd  += int'(a_cmd_en && app_rdy);
            ndone += int'(a_done);
            rd_valid = (k >= 3 && k <= 6);
            tick();
        end
        rd_valid = 1'b0;
        n_checks++; if (ncmd !== 4 || ndone !== 1) $display("FAIL rd_counts: got cmds=%0d dones=%0d want 4/1", ncmd, ndone); else n_pass++;
        n_checks++; if (a_busy !== 1'b0 || a_err !== 1'b0) $display("FAIL rd_end: got busy=%0b err=%0b want 0/0", a_busy, a_err); else n_pass++;
    endtask

    task automatic test_outstanding();
        int ncmd = 0;
        do_reset();
        start = 1'b1; is_write = 1'b0; num_strips = 8'd7; app_rdy = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 3) begin
                n_checks++; if (b_cmd_en !== 1'b0 || b_cmd_idx !== 8'd2) $display("FAIL outst_stall%0d: got en=%0b idx=%0d want 0/2", k, b_cmd_en, b_cmd_idx); else n_pass++;
            end
            if (k == 5) begin
                n_checks++; if (b_cmd_en !== 1'b1) $display("FAIL outst_resume: got %0b want 1", b_cmd_en); else n_pass++;
            end
            if (k >= 5) ncmd += int'(b_cmd_en && app_rdy);
            rd_valid = (k == 4);
            tick();
        end
        n_checks++; if (ncmd !== 1 || b_cmd_idx !== 8'd3) $display("FAIL outst_one_more: got cmds=%0d idx=%0d want 1/3", ncmd, b_cmd_idx); else n_pass++;
        n_checks++; if (b_busy !== 1'b1 || b_err !== 1'b0 || b_done !== 1'b0) $display("FAIL outst_state: got busy=%0b err=%0b done=%0b want 1/0/0", b_busy, b_err, b_done); else n_pass++;
        n_checks++; if (b_wdf_wren !== 1'b0 || b_wdf_end !== 1'b0 || b_data_idx !== 8'd1) $display("FAIL outst_data: got wren=%0b end=%0b didx=%0d want 0/0/1", b_wdf_wren, b_wdf_end, b_data_idx); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL outst_abort: got busy=%0b want 0", b_busy); else n_pass++;
    endtask

    task automatic test_write_burst();
        int nbeat = 0;
        int ncmd = 0;
        int ndone = 0;
        do_reset();
        start = 1'b1; is_write = 1'b1; num_strips = 8'd5; wdf_rdy = 1'b1; app_rdy = 1'b0;
        tick();
        start = 1'b0;
        n_checks++; if (a_wdf_wren !== 1'b1 || a_wdf_end !== 1'b1 || a_cmd_en !== 1'b0) $display("FAIL wr_first: got wren=%0b end=%0b cmd_en=%0b want 1/1/0", a_wdf_wren, a_wdf_end, a_cmd_en); else n_pass++;
        tick();
        tick();
        n_checks++; if (a_wdf_wren !== 1'b0 || a_wdf_end !== 1'b0 || a_data_idx !== 8'd2) $display("FAIL wr_lead: got wren=%0b end=%0b didx=%0d want 0/0/2", a_wdf_wren, a_wdf_end, a_data_idx); else n_pass++;
        tick();
        n_checks++; if (a_wdf_wren !== 1'b0 || a_cmd_en !== 1'b1) $display("FAIL wr_hold: got wren=%0b cmd_en=%0b want 0/1", a_wdf_wren, a_cmd_en); else n_pass++;
        nbeat = 2;
        app_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            nbeat += int'(a_wdf_wren && wdf_rdy);
            ncmd  += int'(a_cmd_en && app_rdy);
            ndone += int'(a_done);
            tick();
        end
        n_checks++; if (nbeat !== 6 || ncmd !== 6 || ndone !== 1) $display("FAIL wr_counts: got beats=%0d cmds=%0d dones=%0d want 6/6/1", nbeat, ncmd, ndone); else n_pass++;
        n_checks++; if (a_busy !== 1'b0 || a_cmd_idx !== 8'd5) $display("FAIL wr_end: got busy=%0b idx=%0d want 0/5", a_busy, a_cmd_idx); else n_pass++;
    endtask

    task automatic test_single_write();
        do_reset();
        start = 1'b1; is_write = 1'b1; num_strips = 8'd0; wdf_rdy = 1'b1; app_rdy = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({a_wdf_wren, a_cmd_en} !== 2'b10) $display("FAIL single_k0: got wren,cmd=%b want 10", {a_wdf_wren, a_cmd_en}); else n_pass++;
        tick();
        n_checks++; if ({a_wdf_wren, a_cmd_en} !== 2'b01) $display("FAIL single_k1: got wren,cmd=%b want 01", {a_wdf_wren, a_cmd_en}); else n_pass++;
        tick();
        n_checks++; if ({a_done, a_busy, a_cmd_en, a_wdf_wren} !== 4'b1100) $display("FAIL single_done: got done,busy,cmd,wren=%b want 1100", {a_done, a_busy, a_cmd_en, a_wdf_wren}); else n_pass++;
        tick();
        n_checks++; if ({a_done, a_busy} !== 2'b00) $display("FAIL single_idle: got done,busy=%b want 00", {a_done, a_busy}); else n_pass++;
    endtask

    task automatic test_err();
        do_reset();
        start = 1'b1; is_write = 1'b0; num_strips = 8'd0; app_rdy = 1'b0;
        tick();
        start = 1'b0; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        n_checks++; if (a_err !== 1'b1 || a_cmd_en !== 1'b1 || a_data_idx !== 8'd0 || a_cmd_idx !== 8'd0) $display("FAIL err_set: got err=%0b cmd_en=%0b idx=%0d/%0d want 1/1/0/0", a_err, a_cmd_en, a_cmd_idx, a_data_idx); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (a_err !== 1'b1 || a_busy !== 1'b0) $display("FAIL err_sticky: got err=%0b busy=%0b want 1/0", a_err, a_busy); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (a_err !== 1'b0) $display("FAIL err_clear: got %0b want 0", a_err); else n_pass++;
        app_rdy = 1'b1;
        tick();
        app_rdy = 1'b0; rd_valid = 1'b1;
        tick();
        n_checks++; if (a_done !== 1'b1) $display("FAIL err_burst_done: got %0b want 1", a_done); else n_pass++;
        tick();
        tick();
        rd_valid = 1'b0;
        n_checks++; if (a_err !== 1'b0 || a_busy !== 1'b0) $display("FAIL err_idle_ignore: got err=%0b busy=%0b want 0/0", a_err, a_busy); else n_pass++;
    endtask

    task automatic test_abort_drain();
        int ncmd = 0;
        int ndone = 0;
        do_reset();
        start = 1'b1; is_write = 1'b0; num_strips = 8'd3; app_rdy = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd_valid = (k >= 2);
            tick();
        end
        rd_valid = 1'b0;
        n_checks++; if (a_busy !== 1'b1 || a_cmd_en !== 1'b0 || a_data_idx !== 8'd2 || a_cmd_idx !== 8'd3) $display("FAIL abort_pre: got busy=%0b en=%0b idx=%0d/%0d want 1/0/3/2", a_busy, a_cmd_en, a_cmd_idx, a_data_idx); else n_pass++;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_cmd_idx !== 8'd0 || a_data_idx !== 8'd0) $display("FAIL abort_idle: got busy=%0b done=%0b idx=%0d/%0d want 0/0/0/0", a_busy, a_done, a_cmd_idx, a_data_idx); else n_pass++;
        tick();
        n_checks++; if (a_busy !== 1'b0) $display("FAIL abort_start_ignored: got busy=%0b want 0", a_busy); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k < 6) ncmd += int'(a_cmd_en && app_rdy);
            if (k == 10) begin
                n_checks++; if (a_done !== 1'b1) $display("FAIL abort_clean_done: got %0b want 1", a_done); else n_pass++;
            end
            ndone += int'(a_done);
            rd_valid = (k >= 6 && k <= 9);
            tick();
        end
        rd_valid = 1'b0;
        n_checks++; if (ncmd !== 4 || ndone !== 1 || a_err !== 1'b0) $display("FAIL abort_clean: got cmds=%0d dones=%0d err=%0b want 4/1/0", ncmd, ndone, a_err); else n_pass++;
    endtask

    task automatic test_max_strips();
        int nbeat = 0;
        int ncmd = 0;
        int ndone = 0;
        int idx_bad = 0;
        do_reset();
        start = 1'b1; is_write = 1'b1; num_strips = 8'd255; wdf_rdy = 1'b1; app_rdy = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (a_cmd_en && app_rdy) begin
                if (int'(a_cmd_idx) != ncmd) idx_bad++;
                ncmd++;
            end
            nbeat += int'(a_wdf_wren && wdf_rdy);
            ndone += int'(a_done);
            tick();
        end
        n_checks++; if (nbeat !== 256 || ncmd !== 256 || ndone !== 1) $display("FAIL max_counts: got beats=%0d cmds=%0d dones=%0d want 256/256/1", nbeat, ncmd, ndone); else n_pass++;
        n_checks++; if (idx_bad !== 0 || a_cmd_idx !== 8'd255 || a_data_idx !== 8'd255) $display("FAIL max_idx: got bad=%0d idx=%0d/%0d want 0/255/255", idx_bad, a_cmd_idx, a_data_idx); else n_pass++;
    endtask

    task automatic test_random();
        logic [21:0] exp_v, got_v;
        rstn = 1'b0;
        model_step();
        tick();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            exp_v = {m_phase != 0, m_phase == 2, m_cmd_en(), m_wren(), m_wren(), m_err,
                     8'(m_idx(m_nc)), 8'(m_idx(m_nd))};
            got_v = {a_busy, a_done, a_cmd_en, a_wdf_wren, a_wdf_end, a_err, a_cmd_idx, a_data_idx};
            n_checks++; if (got_v !== exp_v) $display("FAIL random_cyc%0d: got %h want %h", cyc, got_v, exp_v); else n_pass++;
            rstn     = ($urandom_range(0, 499) != 0);
            start    = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 79) == 0);
            is_write = 1'($urandom_range(0, 1));
            num_strips = ($urandom_range(0, 15) == 0) ? 8'd40 : 8'($urandom_range(0, 6));
            app_rdy  = ($urandom_range(0, 3) != 0);
            wdf_rdy  = ($urandom_range(0, 3) != 0);
            if (m_phase == 1 && m_wr == 0 && m_nc > m_nd) rd_valid = 1'($urandom_range(0, 1));
            else rd_valid = ($urandom_range(0, 39) == 0);
            model_step();
            tick();
        end
        rstn = 1'b1; start = 1'b0; abort = 1'b0; rd_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_mid_run();
        test_read_burst();
        test_outstanding();
        test_write_burst();
        test_single_write();
        test_err();
        test_abort_drain();
        test_max_strips();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
